// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch squash, mul/div hold,
// plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memRead_IDtoEX,
  input  logic [4:0]       writeReg_IDtoEX,
  input  logic [4:0]       readReg1_ID,
  input  logic [4:0]       readReg2_ID,
  input  logic             useRs1_ID,
  input  logic             useRs2_ID,
  input  logic             branchTaken_EX,
  input  logic             mdStart_EX,
  input  logic             mdDone,
  output logic             stallPC,
  output logic             stallIFtoID,
  output logic             stallIDtoEX,
  output logic             flushIFtoID,
  output logic             flushIDtoEX,
  output logic             flushEXtoMEM,
  output logic             mdGo,
  output logic             mdErr,
  output logic             state,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam int unsigned TimerW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  typedef enum logic [0:0] {StRun = 1'b0, StMdWait = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              md_err_q, md_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              load_use, md_hold, branch_flush;

  assign load_use = memRead_IDtoEX && (writeReg_IDtoEX != 5'd0) &&
                    ((useRs1_ID && (readReg1_ID == writeReg_IDtoEX)) ||
                     (useRs2_ID && (readReg2_ID == writeReg_IDtoEX)));

  assign md_hold = ((state_q == StRun) && mdStart_EX) ||
                   ((state_q == StMdWait) && !mdDone && (timer_q != TimerMax));

  assign branch_flush = rst_n && !md_hold && branchTaken_EX;

  // Controls are gated by rst_n so they read 0 for the whole time reset is held.
  always_comb begin
    stallPC      = 1'b0;
    stallIFtoID  = 1'b0;
    stallIDtoEX  = 1'b0;
    flushIFtoID  = 1'b0;
    flushIDtoEX  = 1'b0;
    flushEXtoMEM = 1'b0;
    mdGo         = 1'b0;
    if (rst_n) begin
      mdGo = (state_q == StRun) && mdStart_EX;
      if (md_hold) begin
        stallPC      = 1'b1;
        stallIFtoID  = 1'b1;
        stallIDtoEX  = 1'b1;
        flushEXtoMEM = 1'b1;
      end else if (branchTaken_EX) begin
        flushIFtoID = 1'b1;
        flushIDtoEX = 1'b1;
      end else if (load_use) begin
        stallPC     = 1'b1;
        stallIFtoID = 1'b1;
        flushIDtoEX = 1'b1;
      end
    end
  end

  // The timer counts cycles since mdGo, so the issue cycle is 0 and MD_WAIT
  // spans at most MD_TIMEOUT-1 cycles.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    md_err_d = md_err_q;
    unique case (state_q)
      StRun: begin
        timer_d = '0;
        if (mdStart_EX) begin
          state_d = StMdWait;
          timer_d = TimerW'(1);
        end
      end
      StMdWait: begin
        if (mdDone) begin
          state_d = StRun;
          timer_d = '0;
        end else if (timer_q == TimerMax) begin
          state_d  = StRun;
          timer_d  = '0;
          md_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: begin
        state_d = StRun;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stallPC && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (branch_flush && (flush_cnt_q != CntMax)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      timer_q     <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state      = state_q;
  assign mdErr      = md_err_q;
  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default instance plus a short-timeout,
// narrow-counter instance sharing the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read, use1, use2, br, md_start, md_done;
  logic [4:0] wr, rs1, rs2;

  logic        sp_a, sif_a, sid_a, fif_a, fid_a, fex_a, go_a, err_a, st_a;
  logic        sp_b, sif_b, sid_b, fif_b, fid_b, fex_b, go_b, err_b, st_b;
  logic [15:0] scnt_a, fcnt_a;
  logic [2:0]  scnt_b, fcnt_b;
  logic [6:0]  ctl_a, ctl_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .memRead_IDtoEX(mem_read), .writeReg_IDtoEX(wr),
    .readReg1_ID(rs1), .readReg2_ID(rs2), .useRs1_ID(use1), .useRs2_ID(use2),
    .branchTaken_EX(br), .mdStart_EX(md_start), .mdDone(md_done),
    .stallPC(sp_a), .stallIFtoID(sif_a), .stallIDtoEX(sid_a), .flushIFtoID(fif_a),
    .flushIDtoEX(fid_a), .flushEXtoMEM(fex_a), .mdGo(go_a), .mdErr(err_a), .state(st_a),
    .stallCount(scnt_a), .flushCount(fcnt_a)
  );

  pipeline_hazard_ctrl #(.MD_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .memRead_IDtoEX(mem_read), .writeReg_IDtoEX(wr),
    .readReg1_ID(rs1), .readReg2_ID(rs2), .useRs1_ID(use1), .useRs2_ID(use2),
    .branchTaken_EX(br), .mdStart_EX(md_start), .mdDone(md_done),
    .stallPC(sp_b), .stallIFtoID(sif_b), .stallIDtoEX(sid_b), .flushIFtoID(fif_b),
    .flushIDtoEX(fid_b), .flushEXtoMEM(fex_b), .mdGo(go_b), .mdErr(err_b), .state(st_b),
    .stallCount(scnt_b), .flushCount(fcnt_b)
  );

  // {stallPC, stallIFtoID, stallIDtoEX, flushIFtoID, flushIDtoEX, flushEXtoMEM, mdGo}
  assign ctl_a = {sp_a, sif_a, sid_a, fif_a, fid_a, fex_a, go_a};
  assign ctl_b = {sp_b, sif_b, sid_b, fif_b, fid_b, fex_b, go_b};

  localparam logic [6:0] CtlNone  = 7'b000_0000;
  localparam logic [6:0] CtlLoad  = 7'b110_0100;
  localparam logic [6:0] CtlBr    = 7'b000_1100;
  localparam logic [6:0] CtlMdGo  = 7'b111_0011;
  localparam logic [6:0] CtlMdHld = 7'b111_0010;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mem_read = 1'b0; wr = 5'd0; rs1 = 5'd0; rs2 = 5'd0; use1 = 1'b0; use2 = 1'b0;
    br = 1'b0; md_start = 1'b0; md_done = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with every hazard input active.
    rst_n = 1'b0;
    mem_read = 1'b1; wr = 5'd5; rs1 = 5'd5; rs2 = 5'd5; use1 = 1'b1; use2 = 1'b1;
    br = 1'b1; md_start = 1'b1; md_done = 1'b0;
    settle();
    chk("rst_ctl_a", 32'(ctl_a), 32'(CtlNone));
    chk("rst_ctl_b", 32'(ctl_b), 32'(CtlNone));
    tick();
    chk("rst_state", 32'(st_a), 32'd0);
    chk("rst_scnt", 32'(scnt_a), 32'd0);
    chk("rst_fcnt", 32'(fcnt_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    rst_n = 1'b1;
    idle();
    tick();

    // Load-use on rs1.
    mem_read = 1'b1; wr = 5'd5; rs1 = 5'd5; use1 = 1'b1;
    settle();
    chk("lu_rs1_ctl", 32'(ctl_a), 32'(CtlLoad));
    tick();
    mem_read = 1'b0;
    settle();
    chk("lu_rs1_release", 32'(ctl_a), 32'(CtlNone));
    chk("lu_rs1_scnt", 32'(scnt_a), 32'd1);
    // rd = x0 never stalls.
    mem_read = 1'b1; wr = 5'd0; rs1 = 5'd0; use1 = 1'b1;
    settle();
    chk("lu_x0_ctl", 32'(ctl_a), 32'(CtlNone));
    // rs2 matches but is unused.
    wr = 5'd7; rs1 = 5'd1; rs2 = 5'd7; use2 = 1'b0;
    settle();
    chk("lu_rs2_unused", 32'(ctl_a), 32'(CtlNone));
    use2 = 1'b1;
    settle();
    chk("lu_rs2_ctl", 32'(ctl_a), 32'(CtlLoad));
    tick();
    idle();
    settle();
    chk("lu_rs2_scnt", 32'(scnt_a), 32'd2);

    // Taken branch outranks a concurrent load-use.
    mem_read = 1'b1; wr = 5'd3; rs1 = 5'd3; use1 = 1'b1; br = 1'b1;
    settle();
    chk("br_ctl", 32'(ctl_a), 32'(CtlBr));
    tick();
    idle();
    settle();
    chk("br_fcnt", 32'(fcnt_a), 32'd1);
    chk("br_scnt", 32'(scnt_a), 32'd2);

    // mdDone in RUN is ignored.
    md_done = 1'b1;
    settle();
    chk("md_done_run_ctl", 32'(ctl_a), 32'(CtlNone));
    tick();
    md_done = 1'b0;
    settle();
    chk("md_done_run_state", 32'(st_a), 32'd0);

    // Mul/div: start at T (branch ignored), done at T+4.
    md_start = 1'b1; br = 1'b1;
    settle();
    chk("md_T_ctl", 32'(ctl_a), 32'(CtlMdGo));
    tick();
    br = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      settle();
      chk($sformatf("md_T%0d_ctl", i), 32'(ctl_a), 32'(CtlMdHld));
      chk($sformatf("md_T%0d_state", i), 32'(st_a), 32'd1);
      tick();
    end
    md_done = 1'b1;
    settle();
    chk("md_T4_ctl", 32'(ctl_a), 32'(CtlNone));
    chk("md_T4_state", 32'(st_a), 32'd1);
    tick();
    idle();
    settle();
    chk("md_T5_state", 32'(st_a), 32'd0);
    chk("md_T5_scnt", 32'(scnt_a), 32'd6);
    chk("md_T5_fcnt", 32'(fcnt_a), 32'd1);
    chk("md_T5_err", 32'(err_a), 32'd0);

    // Timeout on the MD_TIMEOUT=4 instance.
    reset_pulse();
    md_start = 1'b1;
    settle();
    chk("to_T_ctl", 32'(ctl_b), 32'(CtlMdGo));
    tick();
    for (int i = 1; i <= 2; i++) begin
      settle();
      chk($sformatf("to_T%0d_ctl", i), 32'(ctl_b), 32'(CtlMdHld));
      tick();
    end
    settle();
    chk("to_T3_ctl", 32'(ctl_b), 32'(CtlNone));
    chk("to_T3_state", 32'(st_b), 32'd1);
    chk("to_T3_err", 32'(err_b), 32'd0);
    tick();
    md_start = 1'b0;
    settle();
    chk("to_T4_state", 32'(st_b), 32'd0);
    chk("to_T4_err", 32'(err_b), 32'd1);
    chk("to_T4_scnt", 32'(scnt_b), 32'd3);
    tick();
    tick();
    chk("to_err_sticky", 32'(err_b), 32'd1);
    reset_pulse();
    chk("to_err_cleared", 32'(err_b), 32'd0);

    // Continuous load-use for 10 cycles: 3-bit counter saturates at 7.
    mem_read = 1'b1; wr = 5'd9; rs2 = 5'd9; use2 = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_scnt_b", 32'(scnt_b), 32'd7);
    chk("sat_scnt_a", 32'(scnt_a), 32'd10);
    chk("sat_ctl_b", 32'(ctl_b), 32'(CtlLoad));
    idle();

    // Asynchronous reset while in MD_WAIT with mdStart still high.
    md_start = 1'b1;
    tick();
    tick();
    chk("rw_pre_state", 32'(st_a), 32'd1);
    rst_n = 1'b0;
    settle();
    chk("rw_ctl_a", 32'(ctl_a), 32'(CtlNone));
    chk("rw_state_a", 32'(st_a), 32'd0);
    chk("rw_scnt_a", 32'(scnt_a), 32'd0);
    chk("rw_fcnt_a", 32'(fcnt_a), 32'd0);
    tick();
    md_start = 1'b0;
    rst_n = 1'b1;
    settle();
    chk("rw_release_ctl", 32'(ctl_a), 32'(CtlNone));
    tick();
    md_start = 1'b1;
    settle();
    chk("rw_fresh_go", 32'(ctl_a), 32'(CtlMdGo));
    tick();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
